// File: rtl/branch_pkg.sv
// Shared branch-resolve types: RV32I branch funct3 codes and the registered result record.
package branch_pkg;

    // Width of redirect_pc inside the result record; the top's XLEN defaults to this.
    localparam int BR_XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic               taken;
        logic               mispredict;
        logic               misaligned;
        logic               illegal;
        logic [BR_XLEN-1:0] redirect_pc;
    } br_result_t;

endpackage

// File: rtl/branch_cond_gen.sv
// Equality and less-than between two operands, signed or unsigned.
// Latency: purely combinational.
// Backpressure: none.
module branch_cond_gen #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            is_signed,
    output logic            eq,
    output logic            lt
);

    logic [XLEN-1:0] sign_flip;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign sign_flip = {is_signed, {(XLEN-1){1'b0}}};
    assign a_mag     = rs1 ^ sign_flip;
    assign b_mag     = rs2 ^ sign_flip;

    assign eq = (rs1 == rs2);
    assign lt = (a_mag < b_mag);

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: decode, condition, redirect target, stats counters.
// Latency: 1 cycle from accept to out_valid through a single result register.
// Backpressure: valid/ready; a held result stalls in_ready, flush discards it.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN  = BR_XLEN,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             pred_taken,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             mispredict,
    output logic             misaligned,
    output logic             illegal,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    logic             eq;
    logic             lt;
    logic             is_signed;
    logic             cond_taken;
    logic             is_illegal;
    logic [XLEN-1:0]  target_pc;
    logic [XLEN-1:0]  seq_pc;
    logic             accept;
    logic             deliver;
    br_result_t       new_res;
    br_result_t       res_d, res_q;
    logic             out_valid_d, out_valid_q;
    logic [CNT_W-1:0] branch_cnt_d, branch_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_d, mispred_cnt_q;

    assign is_signed = (funct3 == F3_BLT) || (funct3 == F3_BGE);

    branch_cond_gen #(.XLEN(XLEN)) u_cond (
        .rs1       (rs1),
        .rs2       (rs2),
        .is_signed (is_signed),
        .eq        (eq),
        .lt        (lt)
    );

    always_comb begin
        cond_taken = 1'b0;
        is_illegal = 1'b0;
        case (funct3)
            F3_BEQ:          cond_taken = eq;
            F3_BNE:          cond_taken = ~eq;
            F3_BLT, F3_BLTU: cond_taken = lt;
            F3_BGE, F3_BGEU: cond_taken = ~lt;
            default:         is_illegal = 1'b1;
        endcase
    end

    assign target_pc = pc + imm;
    assign seq_pc    = pc + XLEN'(4);

    always_comb begin
        new_res             = '0;
        new_res.taken       = cond_taken;
        new_res.illegal     = is_illegal;
        new_res.mispredict  = ~is_illegal & (cond_taken != pred_taken);
        new_res.misaligned  = cond_taken & (target_pc[1:0] != 2'b00);
        new_res.redirect_pc = cond_taken ? target_pc : seq_pc;
    end

    assign in_ready = ~flush & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign deliver  = out_valid_q & out_ready & ~flush;

    always_comb begin
        res_d         = res_q;
        out_valid_d   = out_valid_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            res_d       = new_res;
        end else if (deliver) begin
            out_valid_d = 1'b0;
        end
        // Illegal ops reach commit for trapping but are not counted as branches.
        if (deliver && !res_q.illegal) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
            if (res_q.mispredict) begin
                mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q         <= '0;
            out_valid_q   <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            res_q         <= res_d;
            out_valid_q   <= out_valid_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign taken       = res_q.taken;
    assign mispredict  = res_q.mispredict;
    assign misaligned  = res_q.misaligned;
    assign illegal     = res_q.illegal;
    assign redirect_pc = res_q.redirect_pc;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branch vectors with hand-computed results.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1, rs2, pc, imm;
    logic [2:0]  funct3;
    logic        pred_taken;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        taken;
    logic [31:0] redirect_pc;
    logic        mispredict;
    logic        misaligned;
    logic        illegal;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    typedef struct {
        logic        taken;
        logic        mispredict;
        logic        misaligned;
        logic        illegal;
        logic [31:0] redirect_pc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] exp_bc = '0;
    logic [31:0] exp_mc = '0;
    bit          b_done;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct3      (funct3),
        .pc          (pc),
        .imm         (imm),
        .pred_taken  (pred_taken),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .taken       (taken),
        .redirect_pc (redirect_pc),
        .mispredict  (mispredict),
        .misaligned  (misaligned),
        .illegal     (illegal),
        .branch_cnt  (branch_cnt),
        .mispred_cnt (mispred_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] im, input logic pr,
                        input logic e_tk, input logic [31:0] e_pc, input logic e_mp,
                        input logic e_ma, input logic e_il);
        exp_t e;
        bit   ok = 1'b0;
        funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = im; pred_taken = pr;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        if (ok) begin
            e.taken = e_tk; e.redirect_pc = e_pc; e.mispredict = e_mp;
            e.misaligned = e_ma; e.illegal = e_il;
            exp_q.push_back(e);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: checks occupancy and counters every cycle, pops on each output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            exp_bc = '0;
            exp_mc = '0;
        end else begin
            check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
            check("branch_cnt", branch_cnt, exp_bc);
            check("mispred_cnt", mispred_cnt, exp_mc);
            if (out_valid && exp_q.size() != 0) begin
                if (flush) begin
                    void'(exp_q.pop_front());
                end else if (out_ready) begin
                    e = exp_q.pop_front();
                    check("taken", {31'b0, taken}, {31'b0, e.taken});
                    check("redirect_pc", redirect_pc, e.redirect_pc);
                    check("mispredict", {31'b0, mispredict}, {31'b0, e.mispredict});
                    check("misaligned", {31'b0, misaligned}, {31'b0, e.misaligned});
                    check("illegal", {31'b0, illegal}, {31'b0, e.illegal});
                    if (!e.illegal) begin
                        exp_bc = exp_bc + 32'd1;
                        if (e.mispredict) exp_mc = exp_mc + 32'd1;
                    end
                end
            end
        end
    end

    task automatic check_zero_state(input string tag);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_taken"}, {31'b0, taken}, 32'd0);
        check({tag, "_redirect_pc"}, redirect_pc, 32'd0);
        check({tag, "_mispredict"}, {31'b0, mispredict}, 32'd0);
        check({tag, "_misaligned"}, {31'b0, misaligned}, 32'd0);
        check({tag, "_illegal"}, {31'b0, illegal}, 32'd0);
        check({tag, "_branch_cnt"}, branch_cnt, 32'd0);
        check({tag, "_mispred_cnt"}, mispred_cnt, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        rs1 = '0; rs2 = '0; pc = '0; imm = '0; funct3 = '0; pred_taken = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zero_state("reset");
        @(posedge clk); #1;

        // BEQ taken, predicted not-taken
        send(3'b000, 32'h1234, 32'h1234, 32'h100, 32'h20, 1'b0, 1'b1, 32'h120, 1'b1, 1'b0, 1'b0);
        idle(2);
        @(negedge clk);
        check("beq_branch_cnt", branch_cnt, 32'd1);
        check("beq_mispred_cnt", mispred_cnt, 32'd1);
        @(posedge clk); #1;

        // Signed/unsigned compare pairs, back to back at full throughput
        send(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 1'b1, 1'b1, 32'h240, 1'b0, 1'b0, 1'b0);
        send(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 1'b1, 1'b0, 32'h204, 1'b1, 1'b0, 1'b0);
        send(3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h300, 32'h10, 1'b0, 1'b0, 32'h304, 1'b0, 1'b0, 1'b0);
        send(3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h300, 32'h10, 1'b0, 1'b1, 32'h310, 1'b1, 1'b0, 1'b0);
        send(3'b001, 32'h5, 32'h5, 32'h400, 32'h8, 1'b1, 1'b0, 32'h404, 1'b1, 1'b0, 1'b0);
        // Illegal funct3: no counting, sequential redirect
        send(3'b010, 32'h1, 32'h2, 32'h500, 32'h20, 1'b1, 1'b0, 32'h504, 1'b0, 1'b0, 1'b1);
        send(3'b011, 32'h7, 32'h7, 32'h600, 32'h6, 1'b1, 1'b0, 32'h604, 1'b0, 1'b0, 1'b1);
        // PC wrap, misaligned target (taken and not taken), negative immediate
        send(3'b111, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h8, 1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0);
        send(3'b000, 32'h3, 32'h3, 32'h700, 32'h6, 1'b1, 1'b1, 32'h706, 1'b0, 1'b1, 1'b0);
        send(3'b100, 32'h5, 32'h3, 32'h800, 32'h6, 1'b0, 1'b0, 32'h804, 1'b0, 1'b0, 1'b0);
        send(3'b001, 32'h1, 32'h2, 32'h1000, 32'hFFFF_FFF0, 1'b1, 1'b1, 32'hFF0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Stall: two BNE ops with out_ready low for 3 cycles
        out_ready = 1'b0;
        send(3'b001, 32'h1, 32'h0, 32'h900, 32'h100, 1'b0, 1'b1, 32'hA00, 1'b1, 1'b0, 1'b0);
        b_done = 1'b0;
        fork
            begin
                send(3'b001, 32'h2, 32'h2, 32'h904, 32'h100, 1'b0, 1'b0, 32'h908, 1'b0, 1'b0, 1'b0);
                b_done = 1'b1;
            end
        join_none
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", {31'b0, in_ready}, 32'd0);
            check("stall_taken", {31'b0, taken}, 32'd1);
            check("stall_redirect_pc", redirect_pc, 32'hA00);
            check("stall_mispredict", {31'b0, mispredict}, 32'd1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        for (int i = 0; i < 20 && !b_done; i++) @(posedge clk);
        check("stall_second_accepted", {31'b0, b_done}, 32'd1);
        idle(3);

        // Flush a held result; an op presented during flush must not be captured
        out_ready = 1'b0;
        send(3'b000, 32'h1, 32'h1, 32'hB00, 32'h10, 1'b1, 1'b1, 32'hB10, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        in_valid = 1'b1; funct3 = 3'b000; rs1 = 32'h9; rs2 = 32'h9; pc = 32'hC00;
        @(negedge clk);
        check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        idle(1);

        // Reset with a result held and counters non-zero
        out_ready = 1'b0;
        send(3'b001, 32'h1, 32'h2, 32'hD00, 32'h40, 1'b0, 1'b1, 32'hD40, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_zero_state("midrst");
        @(posedge clk); #1 out_ready = 1'b1;
        send(3'b000, 32'h4, 32'h4, 32'hE00, 32'h8, 1'b1, 1'b1, 32'hE08, 1'b0, 1'b0, 1'b0);
        idle(3);
        @(negedge clk);
        check("post_rst_branch_cnt", branch_cnt, 32'd1);
        check("post_rst_mispred_cnt", mispred_cnt, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
